// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier, 16x16 signed -> 32-bit product.
// One Booth group is retired per clock in CALC. The result is published
// in DONE and held there until the consumer takes it.
module booth_seq_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] prod,
    output logic        busy,
    output logic [2:0]  grp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] prod_q, prod_d;
    logic [2:0]  grp_q, grp_d;

    // Booth datapath signals
    logic [16:0] b_ext;      // multiplier with the implicit b[-1]=0 appended
    logic [2:0]  triplet;
    logic [31:0] a_sext;
    logic [31:0] mag;
    logic        neg;
    logic [31:0] shifted;
    logic [31:0] addend;
    logic [31:0] acc_sum;

    // Decode the current Booth group into a magnitude and a negate flag
    always_comb begin
        b_ext   = {b_q, 1'b0};
        triplet = b_ext[{1'b0, grp_q, 1'b0} +: 3];
        a_sext  = {{16{a_q[15]}}, a_q};
        mag     = 32'd0;
        neg     = 1'b0;
        case (triplet)
            3'b001, 3'b010: begin mag = a_sext;        neg = 1'b0; end
            3'b011:         begin mag = a_sext << 1;   neg = 1'b0; end
            3'b100:         begin mag = a_sext << 1;   neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_sext;        neg = 1'b1; end
            default:        begin mag = 32'd0;         neg = 1'b0; end
        endcase
        // Shift before complementing so the vacated low bits become ones
        // and the single carry-in completes the two's complement negation.
        shifted = mag << {grp_q, 1'b0};
        addend  = neg ? ~shifted : shifted;
        acc_sum = acc_q + addend + {31'd0, neg};
    end

    // Next-state and register-update logic for the three-state controller
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        grp_d   = grp_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 32'd0;
                    grp_d   = 3'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                grp_d = grp_q + 3'd1;
                if (grp_q == 3'd7) begin
                    prod_d  = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers; reset clears everything from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            acc_q   <= 32'd0;
            prod_q  <= 32'd0;
            grp_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            grp_q   <= grp_d;
        end
    end

    // in_ready is forced high while reset is asserted
    assign in_ready  = rst || (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign prod      = prod_q;
    assign grp       = grp_q;

endmodule
